// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg: shared extension-mode encodings and helpers.
// IMM_EXT_BRANCH_EN makes the branch mode (op 011) legal.
package imm_ext_pkg;

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_SIGN   = 3'b001;
  localparam logic [2:0] OP_UPPER  = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;

  function automatic logic op_legal(
    input logic [2:0] op
  );
`ifdef IMM_EXT_BRANCH_EN
    return (op <= OP_BRANCH);
`else
    return (op <= OP_UPPER);
`endif
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core: combinational immediate extension decode.
// IMM_EXT_BRANCH_EN builds the branch (shift-by-2) form.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 16
) (
  input  logic [M-1:0] in_imm,
  input  logic [2:0]   in_op,
  output logic [N-1:0] imm,
  output logic         err
);

  logic [N-1:0] zx;
  logic [N-1:0] sx;
  logic [N-1:0] up;

  assign zx = {{(N-M){1'b0}}, in_imm};
  assign sx = {{(N-M){in_imm[M-1]}}, in_imm};
  assign up = {in_imm, {(N-M){1'b0}}};

`ifdef IMM_EXT_BRANCH_EN
  logic [N-1:0] br;
  assign br = {sx[N-3:0], 2'b00};
`endif

  // Select the extended form; illegal modes yield zero with err.
  always_comb begin
    imm = '0;
    err = ~op_legal(in_op);
    unique case (1'b1)
      (in_op == OP_ZERO):   imm = zx;
      (in_op == OP_SIGN):   imm = sx;
      (in_op == OP_UPPER):  imm = up;
`ifdef IMM_EXT_BRANCH_EN
      (in_op == OP_BRANCH): imm = br;
`endif
      default:              imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender behind a two-entry skid buffer.
// IMM_EXT_BRANCH_EN enables the branch mode in imm_ext_core.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned M = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_imm,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_imm,
  output logic         out_err
);

  if (N < M + 2) begin : g_chk
    $error("imm_ext_pipe: N must be >= M+2");
  end

  logic [N-1:0] c_imm;
  logic         c_err;

  imm_ext_core #(
    .N (N),
    .M (M)
  ) u_core (
    .in_imm (in_imm),
    .in_op  (in_op),
    .imm    (c_imm),
    .err    (c_err)
  );

  logic         ov_q,   ov_d;
  logic [N-1:0] oimm_q, oimm_d;
  logic         oerr_q, oerr_d;
  logic         sv_q,   sv_d;
  logic [N-1:0] simm_q, simm_d;
  logic         serr_q, serr_d;
  logic         rdy_q,  rdy_d;
  logic         acc;
  logic         drain;

  assign acc   = in_valid & rdy_q;
  assign drain = ov_q & out_ready;

  // Skid control: refill output from skid first, else from input.
  always_comb begin
    ov_d   = ov_q;
    oimm_d = oimm_q;
    oerr_d = oerr_q;
    sv_d   = sv_q;
    simm_d = simm_q;
    serr_d = serr_q;
    if (flush) begin
      ov_d = 1'b0;
      sv_d = 1'b0;
    end else if (!ov_q || drain) begin
      if (sv_q) begin
        ov_d   = 1'b1;
        oimm_d = simm_q;
        oerr_d = serr_q;
        sv_d   = 1'b0;
      end else if (acc) begin
        ov_d   = 1'b1;
        oimm_d = c_imm;
        oerr_d = c_err;
      end else begin
        ov_d = 1'b0;
      end
    end else if (acc) begin
      sv_d   = 1'b1;
      simm_d = c_imm;
      serr_d = c_err;
    end
    rdy_d = ~sv_d;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ov_q   <= 1'b0;
      oimm_q <= '0;
      oerr_q <= 1'b0;
      sv_q   <= 1'b0;
      simm_q <= '0;
      serr_q <= 1'b0;
      rdy_q  <= 1'b1;
    end else begin
      ov_q   <= ov_d;
      oimm_q <= oimm_d;
      oerr_q <= oerr_d;
      sv_q   <= sv_d;
      simm_q <= simm_d;
      serr_q <= serr_d;
      rdy_q  <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = ov_q;
  assign out_imm   = oimm_q;
  assign out_err   = oerr_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: random and directed checks against a queue model.
// Define IMM_EXT_BRANCH_EN to exercise the branch mode.
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  logic [32:0] q[$];

  imm_ext_pipe #(
    .N (32),
    .M (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(
    input logic [2:0]  op,
    input logic [15:0] imm
  );
    int s;
    s = int'($signed(imm));
    case (op)
      OP_ZERO:   return {1'b0, 16'h0000, imm};
      OP_SIGN:   return {1'b0, 32'(s)};
      OP_UPPER:  return {1'b0, imm, 16'h0000};
`ifdef IMM_EXT_BRANCH_EN
      OP_BRANCH: return {1'b0, 32'(s * 4)};
`endif
      default:   return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outs();
    chk("ovalid", 64'(out_valid), 64'(q.size() > 0));
    chk("iready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0)
      chk("word", 64'({out_err, out_imm}), 64'(q[0]));
  endtask

  task automatic cycle(
    input logic        v,
    input logic [2:0]  op,
    input logic [15:0] imm,
    input logic        ordy,
    input logic        fl
  );
    bit a;
    in_valid  = v;
    in_op     = op;
    in_imm    = imm;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      a = v && (q.size() < 2);
      if (q.size() > 0 && ordy)
        void'(q.pop_front());
      if (a)
        q.push_back(model(op, imm));
    end
    @(negedge clk);
    check_outs();
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            16'($urandom),
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 31) == 0);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_op     = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_ovalid", 64'(out_valid), 64'd0);
    chk("rst_iready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle(1, OP_SIGN, 16'h8004, 1, 0);
    chk("sext", 64'(out_imm), 64'hFFFF8004);
    chk("sext_err", 64'(out_err), 64'd0);
    cycle(1, OP_UPPER, 16'h1234, 1, 0);
    chk("upper", 64'(out_imm), 64'h12340000);
    cycle(1, OP_ZERO, 16'hFFFF, 1, 0);
    chk("zext", 64'(out_imm), 64'h0000FFFF);
    cycle(1, OP_BRANCH, 16'hFFFF, 1, 0);
`ifdef IMM_EXT_BRANCH_EN
    chk("branch", 64'(out_imm), 64'hFFFFFFFC);
    chk("branch_err", 64'(out_err), 64'd0);
`else
    chk("branch", 64'(out_imm), 64'd0);
    chk("branch_err", 64'(out_err), 64'd1);
`endif
    cycle(1, 3'b111, 16'hABCD, 1, 0);
    chk("illegal", 64'({out_err, out_imm}),
        64'h1_0000_0000);
    cycle(0, OP_ZERO, 16'h0, 1, 0);

    cycle(1, OP_ZERO, 16'h0001, 0, 0);
    cycle(1, OP_ZERO, 16'h0002, 0, 0);
    chk("skid_full", 64'(in_ready), 64'd0);
    chk("hold1", 64'(out_imm), 64'd1);
    cycle(1, OP_ZERO, 16'h0003, 1, 0);
    chk("w2", 64'(out_imm), 64'd2);
    chk("skid_free", 64'(in_ready), 64'd1);
    cycle(1, OP_ZERO, 16'h0003, 1, 0);
    chk("w3", 64'(out_imm), 64'd3);
    cycle(0, OP_ZERO, 16'h0, 1, 0);
    chk("drained", 64'(out_valid), 64'd0);

    cycle(1, OP_ZERO, 16'h0005, 0, 0);
    cycle(1, OP_ZERO, 16'h0006, 0, 0);
    cycle(1, OP_ZERO, 16'h0007, 0, 1);
    chk("flush_ov", 64'(out_valid), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);

    rand_cycles(1500);

    cycle(1, OP_SIGN, 16'h1111, 0, 0);
    cycle(1, OP_SIGN, 16'h2222, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ov", 64'(out_valid), 64'd0);
    chk("arst_rdy", 64'(in_ready), 64'd1);
    chk("arst_imm", 64'(out_imm), 64'd0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    check_outs();
    for (int i = 0; i < 4; i++)
      cycle(0, OP_ZERO, 16'h0, 1, 0);

    rand_cycles(1500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
